// File: rtl/uart_pkg.sv
// Shared register map, STATUS bit layout and engine state types for the
// AXI4-Lite UART.
package uart_pkg;

    localparam logic [1:0] REG_STATUS = 2'd0;
    localparam logic [1:0] REG_WRITE  = 2'd1;
    localparam logic [1:0] REG_READ   = 2'd2;

    localparam int ST_TX_FULL  = 0;
    localparam int ST_TX_EMPTY = 1;
    localparam int ST_RX_FULL  = 2;
    localparam int ST_RX_EMPTY = 3;
    localparam int ST_RX_OVF   = 4;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers and a combinational read port
// (rdata_o always shows the head entry while not empty).
module sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_INC = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A push into a full FIFO still lands when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    assign wr_ptr_d = do_push ? wr_ptr_q + PTR_INC : wr_ptr_q;
    assign rd_ptr_d = do_pop  ? rd_ptr_q + PTR_INC : rd_ptr_q;
    assign rdata_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/axi_lite_uart.sv
// AXI4-Lite slave fronting an 8N1 UART: TX/RX FIFOs, bit-timed TX and RX
// engines, and a four-word register map (STATUS, WRITE, READ, reserved).
module axi_lite_uart
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH   = 32,
    parameter int C_DATA_WIDTH = 32,
    parameter int CLK_FREQ     = 50_000_000,
    parameter int BAUD_RATE    = 115200
) (
    input  logic                      clk,
    input  logic                      nrst,
    input  logic [3:0]                awaddr,
    input  logic [2:0]                awprot,
    input  logic                      awvalid,
    output logic                      awready,
    input  logic [C_DATA_WIDTH-1:0]   wdata,
    input  logic [C_DATA_WIDTH/8-1:0] wstrb,
    input  logic                      wvalid,
    output logic                      wready,
    output logic [1:0]                bresp,
    output logic                      bvalid,
    input  logic                      bready,
    input  logic [3:0]                araddr,
    input  logic [2:0]                arprot,
    input  logic                      arvalid,
    output logic                      arready,
    output logic [C_DATA_WIDTH-1:0]   rdata,
    output logic [1:0]                rresp,
    output logic                      rvalid,
    input  logic                      rready,
    input  logic                      rx,
    output logic                      tx
);

    localparam int DIV   = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DIV / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // FIFO hookup
    logic       tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0] tx_fifo_data;
    logic       rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0] rx_fifo_data;

    // AXI slave state
    logic                    awready_q, awready_d;
    logic                    bvalid_q, bvalid_d;
    logic                    arready_q, arready_d;
    logic                    rvalid_q, rvalid_d;
    logic [C_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [C_DATA_WIDTH-1:0] rd_word;
    logic                    ovf_q, ovf_d;
    logic                    wr_en, rd_en;

    // TX engine state
    tx_state_e        tx_state_q, tx_state_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]       tx_idx_q, tx_idx_d;
    logic [7:0]       tx_shr_q, tx_shr_d;
    logic             tx_bit_end;

    // RX engine state
    rx_state_e        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]       rx_idx_q, rx_idx_d;
    logic [7:0]       rx_shr_q, rx_shr_d;
    logic             rx_s1_q, rx_s2_q, rx_prev_q;
    logic             rx_bit_end;

    logic unused_inputs;
    assign unused_inputs = ^{awprot, arprot, wstrb, wdata[C_DATA_WIDTH-1:8],
                             awaddr[1:0], araddr[1:0]};

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk_i   (clk),
        .rst_ni  (nrst),
        .push_i  (tx_push),
        .wdata_i (wdata[7:0]),
        .pop_i   (tx_pop),
        .rdata_o (tx_fifo_data),
        .full_o  (tx_full),
        .empty_o (tx_empty)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk_i   (clk),
        .rst_ni  (nrst),
        .push_i  (rx_push),
        .wdata_i (rx_shr_q),
        .pop_i   (rx_pop),
        .rdata_o (rx_fifo_data),
        .full_o  (rx_full),
        .empty_o (rx_empty)
    );

    // AXI-Lite slave: a write/read takes effect on the cycle its ready pulse is high
    assign wr_en   = awready_q && awvalid && wvalid;
    assign rd_en   = arready_q && arvalid;
    assign tx_push = wr_en && (awaddr[3:2] == REG_WRITE);
    assign rx_pop  = rd_en && (araddr[3:2] == REG_READ) && !rx_empty;

    always_comb begin
        rd_word = '0;
        case (araddr[3:2])
            REG_STATUS: begin
                rd_word[ST_TX_FULL]  = tx_full;
                rd_word[ST_TX_EMPTY] = tx_empty;
                rd_word[ST_RX_FULL]  = rx_full;
                rd_word[ST_RX_EMPTY] = rx_empty;
                rd_word[ST_RX_OVF]   = ovf_q;
            end
            REG_READ: begin
                if (!rx_empty) begin
                    rd_word[7:0] = rx_fifo_data;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        awready_d = awvalid && wvalid && !bvalid_q && !awready_q;
        arready_d = arvalid && !rvalid_q && !arready_q;

        bvalid_d = bvalid_q;
        if (wr_en) begin
            bvalid_d = 1'b1;
        end else if (bready) begin
            bvalid_d = 1'b0;
        end

        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        if (rd_en) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_word;
        end else if (rready) begin
            rvalid_d = 1'b0;
        end

        // A new overflow outranks a simultaneous clear so the event is never lost.
        ovf_d = ovf_q;
        if (rx_push && rx_full && !rx_pop) begin
            ovf_d = 1'b1;
        end else if (wr_en && (awaddr[3:2] == REG_STATUS)) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            ovf_q     <= 1'b0;
        end else begin
            awready_q <= awready_d;
            bvalid_q  <= bvalid_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            ovf_q     <= ovf_d;
        end
    end

    assign awready = awready_q;
    assign wready  = awready_q;
    assign bvalid  = bvalid_q;
    assign bresp   = 2'b00;
    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign rresp   = 2'b00;

    // TX engine
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_shr_q   <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_idx_q   <= tx_idx_d;
            tx_shr_q   <= tx_shr_d;
        end
    end

    assign tx_bit_end = (tx_cnt_q == BIT_LAST);

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + CNT_ONE;
        tx_idx_d   = tx_idx_q;
        tx_shr_d   = tx_shr_q;
        case (tx_state_q)
            TX_IDLE: begin
                tx_cnt_d = '0;
                if (!tx_empty) begin
                    tx_state_d = TX_START;
                    tx_shr_d   = tx_fifo_data;
                end
            end
            TX_START: begin
                if (tx_bit_end) begin
                    tx_state_d = TX_DATA;
                    tx_cnt_d   = '0;
                    tx_idx_d   = '0;
                end
            end
            TX_DATA: begin
                if (tx_bit_end) begin
                    tx_cnt_d = '0;
                    tx_shr_d = {1'b0, tx_shr_q[7:1]};
                    tx_idx_d = tx_idx_q + 3'd1;
                    if (tx_idx_q == 3'd7) begin
                        tx_state_d = TX_STOP;
                    end
                end
            end
            TX_STOP: begin
                // Chain straight into the next start bit so frames stay gapless.
                if (tx_bit_end) begin
                    tx_cnt_d = '0;
                    if (!tx_empty) begin
                        tx_state_d = TX_START;
                        tx_shr_d   = tx_fifo_data;
                    end else begin
                        tx_state_d = TX_IDLE;
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_comb begin
        tx_pop = !tx_empty &&
                 ((tx_state_q == TX_IDLE) || ((tx_state_q == TX_STOP) && tx_bit_end));
        case (tx_state_q)
            TX_START: tx = 1'b0;
            TX_DATA:  tx = tx_shr_q[0];
            default:  tx = 1'b1;
        endcase
    end

    // RX engine
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_shr_q   <= '0;
        end else begin
            rx_s1_q    <= rx;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_idx_q   <= rx_idx_d;
            rx_shr_q   <= rx_shr_d;
        end
    end

    assign rx_bit_end = (rx_cnt_q == BIT_LAST);

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + CNT_ONE;
        rx_idx_d   = rx_idx_q;
        rx_shr_d   = rx_shr_q;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (rx_prev_q && !rx_s2_q) begin
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                // Half a bit in: still low means a real start, otherwise a glitch.
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_idx_d   = '0;
                    rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_bit_end) begin
                    rx_cnt_d = '0;
                    rx_shr_d = {rx_s2_q, rx_shr_q[7:1]};
                    rx_idx_d = rx_idx_q + 3'd1;
                    if (rx_idx_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (rx_bit_end) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        rx_push = (rx_state_q == RX_STOP) && rx_bit_end && rx_s2_q;
    end

endmodule

// File: tb/tb_axi_lite_uart.sv
// Directed bench for axi_lite_uart with TX/RX byte scoreboards; the baud is
// scaled down (DIV = 41) so every frame-level scenario fits a short run.
module tb_axi_lite_uart;

    localparam int CLK_FREQ  = 4_000_000;
    localparam int BAUD_RATE = 96_000;
    localparam int DIV       = CLK_FREQ / BAUD_RATE;

    logic        clk = 1'b0;
    logic        nrst;
    logic [3:0]  awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [3:0]  araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic        rx;
    logic        tx;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int b2b_cnt  = 0;
    bit mon_en   = 1'b0;

    logic [7:0] tx_exp[$];
    logic [7:0] rx_exp[$];

    axi_lite_uart #(
        .FIFO_DEPTH   (32),
        .C_DATA_WIDTH (32),
        .CLK_FREQ     (CLK_FREQ),
        .BAUD_RATE    (BAUD_RATE)
    ) dut (
        .clk     (clk),
        .nrst    (nrst),
        .awaddr  (awaddr),
        .awprot  (awprot),
        .awvalid (awvalid),
        .awready (awready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wvalid  (wvalid),
        .wready  (wready),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready),
        .araddr  (araddr),
        .arprot  (arprot),
        .arvalid (arvalid),
        .arready (arready),
        .rdata   (rdata),
        .rresp   (rresp),
        .rvalid  (rvalid),
        .rready  (rready),
        .rx      (rx),
        .tx      (tx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data);
        bit seen;
        @(negedge clk);
        awaddr  = addr;
        wdata   = data;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        bready  = 1'b1;
        seen    = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = awready && wready;
        end
        check("aw_handshake", {31'b0, seen}, 32'd1);
        @(posedge clk);
        #1;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        seen    = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = bvalid;
        end
        check("b_valid", {31'b0, seen}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
        bit seen;
        @(negedge clk);
        araddr  = addr;
        arvalid = 1'b1;
        rready  = 1'b1;
        seen    = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = arready;
        end
        check("ar_handshake", {31'b0, seen}, 32'd1);
        @(posedge clk);
        #1;
        arvalid = 1'b0;
        seen    = 1'b0;
        data    = 32'hDEAD_BEEF;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (rvalid) begin
                seen = 1'b1;
                data = rdata;
            end
        end
        check("r_valid", {31'b0, seen}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic rx_read_check(input string tag);
        logic [31:0] got;
        logic [31:0] exp;
        exp = '0;
        if (rx_exp.size() > 0) exp = {24'b0, rx_exp.pop_front()};
        axi_read(4'h8, got);
        check(tag, got, exp);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (DIV) @(negedge clk);
        end
        rx = stop_bit;
        repeat (DIV) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic wait_tx_drain();
        for (int i = 0; i < 34 * 10 * DIV + 200 && tx_exp.size() != 0; i++) begin
            @(negedge clk);
        end
        repeat (12 * DIV) @(negedge clk);
        check("tx_drain_left", tx_exp.size(), 32'd0);
    endtask

    // Decodes every frame on tx and checks its bit timing and payload.
    initial begin : tx_monitor
        logic       prev;
        logic [7:0] byte_v;
        logic [7:0] exp_b;
        logic       lvl_first, lvl_mid, lvl_last;
        bit         shape_ok;
        int         prev_end;
        prev     = 1'b1;
        prev_end = -100;
        lvl_first = 1'b1;
        lvl_mid   = 1'b1;
        lvl_last  = 1'b1;
        forever begin
            @(negedge clk);
            if (mon_en && prev && !tx) begin
                if (cyc == prev_end + 1) b2b_cnt++;
                shape_ok = 1'b1;
                byte_v   = '0;
                for (int k = 0; k < 10; k++) begin
                    for (int j = 0; j < DIV; j++) begin
                        if (k != 0 || j != 0) @(negedge clk);
                        if (j == 0)       lvl_first = tx;
                        if (j == DIV / 2) lvl_mid   = tx;
                        if (j == DIV - 1) lvl_last  = tx;
                    end
                    if (lvl_first !== lvl_last || lvl_first !== lvl_mid) shape_ok = 1'b0;
                    if (k == 0 && lvl_mid !== 1'b0) shape_ok = 1'b0;
                    if (k == 9 && lvl_mid !== 1'b1) shape_ok = 1'b0;
                    if (k >= 1 && k <= 8) byte_v[k-1] = lvl_mid;
                end
                prev_end = cyc;
                check("tx_frame_expected", {31'b0, tx_exp.size() > 0}, 32'd1);
                if (tx_exp.size() > 0) begin
                    exp_b = tx_exp.pop_front();
                    check("tx_byte", {24'b0, byte_v}, {24'b0, exp_b});
                end
                check("tx_frame_shape", {31'b0, shape_ok}, 32'd1);
            end
            prev = tx;
        end
    end

    initial begin : watchdog
        #900_000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", n_err, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [31:0] d;
        int          b0;
        int          low_cnt;

        nrst    = 1'b0;
        awaddr  = '0;
        awprot  = '0;
        awvalid = 1'b0;
        wdata   = '0;
        wstrb   = 4'hF;
        wvalid  = 1'b0;
        bready  = 1'b0;
        araddr  = '0;
        arprot  = '0;
        arvalid = 1'b0;
        rready  = 1'b0;
        rx      = 1'b1;

        repeat (5) @(negedge clk);
        check("rst_tx", {31'b0, tx}, 32'd1);
        check("rst_ready", {28'b0, awready, wready, arready, bvalid}, 32'd0);
        check("rst_rvalid", {31'b0, rvalid}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_resp", {28'b0, bresp, rresp}, 32'd0);
        nrst   = 1'b1;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);
        axi_read(4'h0, d);
        check("status_reset", d, 32'h0000_000A);
        check("tx_idle", {31'b0, tx}, 32'd1);

        b0 = b2b_cnt;
        for (int i = 1; i <= 5; i++) begin
            tx_exp.push_back(8'(i));
            axi_write(4'h4, 32'(i));
        end
        axi_read(4'h4, d);
        check("write_reg_reads_zero", d, 32'd0);
        wait_tx_drain();
        check("tx_back_to_back_5", b2b_cnt - b0, 32'd4);
        axi_read(4'h0, d);
        check("status_tx_done", d, 32'h0000_000A);

        for (int i = 0; i < 5; i++) begin
            rx_exp.push_back(8'h11 + 8'(i));
            send_byte(8'h11 + 8'(i), 1'b1);
        end
        repeat (5) rx_read_check("rx_byte");
        axi_read(4'h8, d);
        check("rx_empty_read", d, 32'd0);
        axi_read(4'h0, d);
        check("status_rx_empty", d, 32'h0000_000A);

        send_byte(8'h77, 1'b0);
        repeat (DIV) @(negedge clk);
        rx = 1'b0;
        repeat (10) @(negedge clk);
        rx = 1'b1;
        repeat (2 * DIV) @(negedge clk);
        axi_read(4'h0, d);
        check("status_after_errors", d, 32'h0000_000A);
        rx_exp.push_back(8'h3C);
        send_byte(8'h3C, 1'b1);
        rx_read_check("rx_after_errors");

        for (int i = 0; i < 33; i++) begin
            if (i < 32) rx_exp.push_back(8'h40 + 8'(i));
            send_byte(8'h40 + 8'(i), 1'b1);
        end
        axi_read(4'h0, d);
        check("status_overflow", d, 32'h0000_0016);
        axi_write(4'hC, 32'hFFFF_FFFF);
        axi_read(4'hC, d);
        check("reserved_reads_zero", d, 32'd0);
        axi_write(4'h0, 32'd0);
        axi_read(4'h0, d);
        check("status_ovf_cleared", d, 32'h0000_0006);
        repeat (32) rx_read_check("rx_ovf_byte");
        axi_read(4'h0, d);
        check("status_rx_drained", d, 32'h0000_000A);

        b0 = b2b_cnt;
        for (int i = 0; i < 40; i++) begin
            if (i < 33) tx_exp.push_back(8'hA0 + 8'(i));
            axi_write(4'h4, 32'hA0 + 32'(i));
        end
        axi_read(4'h0, d);
        check("status_tx_full", d, 32'h0000_0009);
        wait_tx_drain();
        check("tx_back_to_back_33", b2b_cnt - b0, 32'd32);

        send_byte(8'h99, 1'b1);
        mon_en = 1'b0;
        axi_write(4'h4, 32'h5A);
        axi_write(4'h4, 32'hC3);
        repeat (3 * DIV) @(negedge clk);
        check("tx_low_before_rst", {31'b0, tx}, 32'd0);
        nrst = 1'b0;
        #1;
        check("rst_tx_forced", {31'b0, tx}, 32'd1);
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        axi_read(4'h0, d);
        check("status_after_rst", d, 32'h0000_000A);
        axi_read(4'h8, d);
        check("rx_flushed", d, 32'd0);
        low_cnt = 0;
        repeat (12 * DIV) begin
            @(negedge clk);
            if (!tx) low_cnt++;
        end
        check("tx_quiet_after_rst", low_cnt, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
